secuenciador_banco_filtros: RTL

//  Time-shares one filter datapath among K bands (e.g. 200 Hz low-pass, band-pass, high-pass) per ADC sample.
//  On each Bandera_ADC it runs the sample through every band, weights each output by a per-band gain,

---
 rtl/banco_filtros_pkg.sv | 41 ++++
 rtl/mult_ganancia_sat.sv | 36 +++
 rtl/secuenciador_banco_filtros.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/banco_filtros_pkg.sv
// ---------------------------------------------------------------------------
// banco_filtros_pkg
// Shared definitions for the filter-bank sequencer:
//   - estado_t      : sequencer FSM state encoding
//   - GAIN_FRAC     : fractional bits of the unsigned Q1.7 band gains
//   - *_DEF         : default sample width, band count, gain width, timeout
//   - sat_n()       : clamps a wide signed value to an n-bit signed range
// ---------------------------------------------------------------------------
package banco_filtros_pkg;

    localparam int GAIN_FRAC   = 7;
    localparam int N_DEF       = 25;
    localparam int K_DEF       = 3;
    localparam int G_DEF       = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_ACUM,
        ST_DONE
    } estado_t;

    // Clamp x to [-2^(n-1), 2^(n-1)-1]; caller keeps the low n bits.
    function automatic logic signed [63:0] sat_n(input logic signed [63:0] x,
                                                 input int n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/mult_ganancia_sat.sv
// ---------------------------------------------------------------------------
// mult_ganancia_sat
// Combinational weighting of one band result: signed sample times unsigned
// Q1.7 gain, then an arithmetic right shift by GAIN_FRAC (floor rounding).
// Ports:
//   dato      in   N       signed filter output of the band
//   ganancia  in   G       unsigned Q1.7 gain (128 = 1.0)
//   termino   out  OUT_W   signed weighted term, sign-extended/truncated
// ---------------------------------------------------------------------------
module mult_ganancia_sat
    import banco_filtros_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int G     = G_DEF,
    parameter int OUT_W = N_DEF + 4
) (
    input  logic signed [N-1:0]     dato,
    input  logic        [G-1:0]     ganancia,
    output logic signed [OUT_W-1:0] termino
);

    localparam int PROD_W = N + G + 1;

    logic signed [PROD_W-1:0] dato_ext;
    logic signed [PROD_W-1:0] gan_ext;
    logic signed [PROD_W-1:0] producto;
    logic signed [PROD_W-1:0] desplazado;

    // The gain is zero-extended so that a gain of 255 stays positive.
    assign dato_ext   = {{(G + 1){dato[N-1]}}, dato};
    assign gan_ext    = {{(N + 1){1'b0}}, ganancia};
    assign producto   = dato_ext * gan_ext;
    assign desplazado = producto >>> GAIN_FRAC;
    assign termino    = OUT_W'(desplazado);

endmodule

// File: rtl/secuenciador_banco_filtros.sv
// ---------------------------------------------------------------------------
// secuenciador_banco_filtros
// Time-shares one external filter among K bands for every ADC sample. Each
// band result is weighted by its gain, accumulated, and the saturated sum is
// presented on Yk together with a one-cycle Bandera_Listo pulse.
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   Uk, Bandera_ADC ADC sample and its one-cycle strobe
//   Ganancias       K packed Q1.7 gains, band i at [i*G +: G]
//   Filt_Sel        band select to the shared filter
//   Filt_Uk         sample presented to the shared filter
//   Filt_Start      one-cycle start pulse to the filter
//   Filt_Yk         filter result, valid with Filt_Listo
//   Filt_Listo      one-cycle filter-done strobe
//   Yk              saturated weighted sum (held between frames)
//   Bandera_Listo   one-cycle Yk-valid pulse
//   Ocupado         frame in progress
//   Overrun         sticky: sample strobe arrived while busy
//   Error           sticky: a band timed out waiting for the filter
// ---------------------------------------------------------------------------
module secuenciador_banco_filtros
    import banco_filtros_pkg::*;
#(
    parameter  int N       = N_DEF,
    parameter  int K       = K_DEF,
    parameter  int G       = G_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int SEL_W   = (K > 1) ? $clog2(K) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N-1:0]     Uk,
    input  logic             Bandera_ADC,
    input  logic [K*G-1:0]   Ganancias,
    output logic [SEL_W-1:0] Filt_Sel,
    output logic [N-1:0]     Filt_Uk,
    output logic             Filt_Start,
    input  logic [N-1:0]     Filt_Yk,
    input  logic             Filt_Listo,
    output logic [N-1:0]     Yk,
    output logic             Bandera_Listo,
    output logic             Ocupado,
    output logic             Overrun,
    output logic             Error
);

    // Two guard bits on top of the band-count growth: the sum cannot wrap.
    localparam int ACC_W = N + $clog2(K) + 2;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    estado_t                 estado_q,  estado_d;
    logic [SEL_W-1:0]        band_q,    band_d;
    logic [N-1:0]            uk_q,      uk_d;
    logic [K*G-1:0]          gains_q,   gains_d;
    logic [N-1:0]            ybanda_q,  ybanda_d;
    logic signed [ACC_W-1:0] acc_q,     acc_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [N-1:0]            yk_q,      yk_d;
    logic                    listo_q,   listo_d;
    logic                    overrun_q, overrun_d;
    logic                    error_q,   error_d;

    logic [G-1:0]            gain_sel;
    logic signed [ACC_W-1:0] termino;

    assign gain_sel = gains_q[int'(band_q) * G +: G];

    mult_ganancia_sat #(
        .N     (N),
        .G     (G),
        .OUT_W (ACC_W)
    ) u_mult (
        .dato     (ybanda_q),
        .ganancia (gain_sel),
        .termino  (termino)
    );

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado_q  <= ST_IDLE;
            band_q    <= '0;
            uk_q      <= '0;
            gains_q   <= '0;
            ybanda_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            yk_q      <= '0;
            listo_q   <= 1'b0;
            overrun_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            band_q    <= band_d;
            uk_q      <= uk_d;
            gains_q   <= gains_d;
            ybanda_q  <= ybanda_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            yk_q      <= yk_d;
            listo_q   <= listo_d;
            overrun_q <= overrun_d;
            error_q   <= error_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        estado_d   = estado_q;
        band_d     = band_q;
        uk_d       = uk_q;
        gains_d    = gains_q;
        ybanda_d   = ybanda_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        yk_d       = yk_q;
        listo_d    = 1'b0;
        overrun_d  = overrun_q;
        error_d    = error_q;
        Filt_Start = 1'b0;

        // Any strobe outside IDLE (DONE included) is dropped and flagged.
        if (Bandera_ADC && (estado_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (estado_q)
            ST_IDLE: begin
                if (Bandera_ADC) begin
                    uk_d     = Uk;
                    gains_d  = Ganancias;
                    band_d   = '0;
                    acc_d    = '0;
                    estado_d = ST_START;
                end
            end
            ST_START: begin
                Filt_Start = 1'b1;
                cnt_d      = '0;
                estado_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (Filt_Listo) begin
                    ybanda_d = Filt_Yk;
                    estado_d = ST_ACUM;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // A silent band contributes nothing to the sum.
                    ybanda_d = '0;
                    error_d  = 1'b1;
                    estado_d = ST_ACUM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACUM: begin
                acc_d = acc_q + termino;
                if (band_q == SEL_W'(K - 1)) begin
                    estado_d = ST_DONE;
                end else begin
                    band_d   = band_q + SEL_W'(1);
                    estado_d = ST_START;
                end
            end
            ST_DONE: begin
                yk_d     = N'(sat_n(64'(acc_q), N));
                listo_d  = 1'b1;
                estado_d = ST_IDLE;
            end
            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    // Sel/Uk come straight from registers, so they stay stable through WAIT.
    assign Filt_Sel      = band_q;
    assign Filt_Uk       = uk_q;
    assign Yk            = yk_q;
    assign Bandera_Listo = listo_q;
    assign Ocupado       = (estado_q != ST_IDLE);
    assign Overrun       = overrun_q;
    assign Error         = error_q;

endmodule
